// File: rtl/ifsram_pd_sched.sv
// ----------------------------------------------------------------------------
// ifsram_pd_sched
// Per-layer column scheduler for the ifmap SRAM fill path. For each tile
// column it picks the master state (LEFT/NORMAL/RIGH), runs the padding
// generator handshake (only on padded edge columns), then the ifmap loader
// handshake. It then presents the filled tile to compute and waits for the
// release before it moves to the next column.
//
// Ports:
//   clk           clock
//   reset         synchronous active-low reset (0 = reset)
//   sch_start     one-cycle layer start pulse, honoured only while idle
//   cfg_col_last  index of the last tile column (0 = single column)
//   cfg_pad_en    layer uses left/right padding
//   sch_busy      high while a layer is in progress (not IDLE)
//   sch_done      one-cycle pulse after the last column is released
//   cur_col       column currently being filled or held
//   mast_state    1 = LEFT, 2 = NORMAL, 3 = RIGH (padding cfg_mast_state)
//   pd_start      one-cycle start pulse to the padding generator
//   pd_done       padding generator done pulse
//   ld_start      one-cycle start pulse to the ifmap loader
//   ld_done       ifmap loader done pulse
//   tile_ready    filled tile available to compute
//   tile_release  compute has consumed the tile
//
// Every output is a register or a decode of the state register, so there is
// no combinational path from any input to any output.
// ----------------------------------------------------------------------------
module ifsram_pd_sched #(
    parameter int COLW  = 8,
    parameter int MST_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sch_start,
    input  logic [COLW-1:0]  cfg_col_last,
    input  logic             cfg_pad_en,
    output logic             sch_busy,
    output logic             sch_done,
    output logic [COLW-1:0]  cur_col,
    output logic [MST_W-1:0] mast_state,
    output logic             pd_start,
    input  logic             pd_done,
    output logic             ld_start,
    input  logic             ld_done,
    output logic             tile_ready,
    input  logic             tile_release
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PAD     = 3'd1,
        S_WAIT_PD = 3'd2,
        S_LOAD    = 3'd3,
        S_WAIT_LD = 3'd4,
        S_READY   = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    localparam logic [MST_W-1:0] MST_LEFT = MST_W'(1);
    localparam logic [MST_W-1:0] MST_NORM = MST_W'(2);
    localparam logic [MST_W-1:0] MST_RIGH = MST_W'(3);
    localparam logic [COLW-1:0]  COL_ZERO = {COLW{1'b0}};
    localparam logic [COLW-1:0]  COL_ONE  = COLW'(1);

    // Master state of a column: column 0 is always LEFT, so a single-column
    // layer starts LEFT and is switched to RIGH only for its second pad pass.
    function automatic logic [MST_W-1:0] f_mast(input logic [COLW-1:0] col,
                                                input logic [COLW-1:0] last);
        if (col == COL_ZERO) begin
            return MST_LEFT;
        end else if (col == last) begin
            return MST_RIGH;
        end else begin
            return MST_NORM;
        end
    endfunction

    // A column needs the padding generator only on the layer's edge columns.
    function automatic logic f_need_pad(input logic [COLW-1:0] col,
                                        input logic [COLW-1:0] last,
                                        input logic            pad_en);
        return pad_en && ((col == COL_ZERO) || (col == last));
    endfunction

    state_t            r_state;
    state_t            w_state_nxt;
    logic [COLW-1:0]   r_cur_col;
    logic [COLW-1:0]   r_col_last;
    logic              r_pad_en;
    logic              r_pass;
    logic [MST_W-1:0]  r_mast;

    logic [COLW-1:0]   w_next_col;
    logic              w_last_col;
    logic              w_second_pass;

    assign w_next_col    = r_cur_col + COL_ONE;
    assign w_last_col    = (r_cur_col == r_col_last);
    // Single padded column: both left and right pads run on the same column.
    assign w_second_pass = (r_col_last == COL_ZERO) && r_pad_en && !r_pass;

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; done/release inputs only matter in their wait state.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (sch_start) begin
                    w_state_nxt = f_need_pad(COL_ZERO, cfg_col_last, cfg_pad_en) ? S_PAD : S_LOAD;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_PAD:     w_state_nxt = S_WAIT_PD;
            S_WAIT_PD: begin
                if (pd_done) begin
                    w_state_nxt = w_second_pass ? S_PAD : S_LOAD;
                end else begin
                    w_state_nxt = S_WAIT_PD;
                end
            end
            S_LOAD:    w_state_nxt = S_WAIT_LD;
            S_WAIT_LD: begin
                if (ld_done) begin
                    w_state_nxt = S_READY;
                end else begin
                    w_state_nxt = S_WAIT_LD;
                end
            end
            S_READY: begin
                if (!tile_release) begin
                    w_state_nxt = S_READY;
                end else if (w_last_col) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = f_need_pad(w_next_col, r_col_last, r_pad_en) ? S_PAD : S_LOAD;
                end
            end
            S_DONE:    w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // Column, pass flag, master state and sampled layer configuration.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cur_col  <= COL_ZERO;
            r_col_last <= COL_ZERO;
            r_pad_en   <= 1'b0;
            r_pass     <= 1'b0;
            r_mast     <= MST_NORM;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (sch_start) begin
                        r_col_last <= cfg_col_last;
                        r_pad_en   <= cfg_pad_en;
                        r_cur_col  <= COL_ZERO;
                        r_pass     <= 1'b0;
                        r_mast     <= f_mast(COL_ZERO, cfg_col_last);
                    end
                end
                S_WAIT_PD: begin
                    if (pd_done && w_second_pass) begin
                        r_pass <= 1'b1;
                        r_mast <= MST_RIGH;
                    end
                end
                S_READY: begin
                    if (tile_release && !w_last_col) begin
                        r_cur_col <= w_next_col;
                        r_pass    <= 1'b0;
                        r_mast    <= f_mast(w_next_col, r_col_last);
                    end
                end
                default: begin
                    r_cur_col <= r_cur_col;
                end
            endcase
        end
    end

    // Output decode from the state register only.
    always_comb begin
        sch_busy   = 1'b0;
        sch_done   = 1'b0;
        pd_start   = 1'b0;
        ld_start   = 1'b0;
        tile_ready = 1'b0;
        case (r_state)
            S_IDLE:    sch_busy = 1'b0;
            S_PAD:     begin sch_busy = 1'b1; pd_start   = 1'b1; end
            S_WAIT_PD: sch_busy = 1'b1;
            S_LOAD:    begin sch_busy = 1'b1; ld_start   = 1'b1; end
            S_WAIT_LD: sch_busy = 1'b1;
            S_READY:   begin sch_busy = 1'b1; tile_ready = 1'b1; end
            S_DONE:    begin sch_busy = 1'b1; sch_done   = 1'b1; end
            default:   sch_busy = 1'b0;
        endcase
    end

    assign cur_col    = r_cur_col;
    assign mast_state = r_mast;

endmodule
